// File: rtl/timer_multi_ch_if.sv
// APB slave bundle for the multi-channel timer: 8-bit byte address, 32-bit data,
// no wait states. The master modport is what a bus driver or testbench uses.
interface timer_multi_ch_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_multi_ch.sv
// Multi-channel APB timer: NCH independent CNT_W-bit up/down counters sharing one
// free-running 4-bit prescaler. Per channel: TDR (0x0), TCR (0x4), TSR (0x8) and a
// read-only TCNT (0xC), channel c at base 0x10*c.
// Optional feature: define TIMER_AUTO_RELOAD_EN to implement TCR[3] arld, which
// replaces the wrap value by TDR on overflow and underflow.
module timer_multi_ch #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16
) (
  input  logic              pclk,
  input  logic              preset,
  timer_multi_ch_if.slave   apb,
  output logic [NCH-1:0]    irq
);

  logic [3:0]       psc;
  logic [CNT_W-1:0] tdr  [NCH];
  logic [CNT_W-1:0] tcnt [NCH];
  logic [1:0]       cks  [NCH];
  logic [NCH-1:0]   load, ie, updw, en, arld, udf, ovf;
  logic [NCH-1:0]   tick, set_ovf, set_udf, wr_ch;
  logic [3:0]       sel_ch;
  logic [1:0]       sel_off;
  logic             addr_ok, access, wr;

  assign sel_ch      = apb.paddr[7:4];
  assign sel_off     = apb.paddr[3:2];
  assign addr_ok     = (int'(sel_ch) < NCH) && (apb.paddr[1:0] == 2'b00);
  assign access      = apb.psel & apb.penable;
  assign apb.pslverr = access & (~addr_ok | (apb.pwrite & (sel_off == 2'd3)));
  assign apb.pready  = 1'b1;
  assign wr          = access & apb.pwrite & ~apb.pslverr;
  assign irq         = ie & (udf | ovf);

  // cks selects how many low prescaler bits must all be set for a tick
  function automatic logic tick_of(input logic [1:0] k, input logic [3:0] p);
    case (k)
      2'd0:    return p[0];
      2'd1:    return &p[1:0];
      2'd2:    return &p[2:0];
      default: return &p;
    endcase
  endfunction

  // Per-channel write strobe, tick and wrap detection; load suppresses counting
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wr_ch[c]   = wr && (sel_ch == 4'(c));
      tick[c]    = tick_of(cks[c], psc);
      set_ovf[c] = ~load[c] & en[c] & tick[c] & ~updw[c] & (tcnt[c] == '1);
      set_udf[c] = ~load[c] & en[c] & tick[c] &  updw[c] & (tcnt[c] == '0);
    end
  end

  // Read mux: zero unless selected at a mapped address
  always_comb begin
    apb.prdata = '0;
    if (apb.psel && addr_ok) begin
      for (int c = 0; c < NCH; c++) begin
        if (sel_ch == 4'(c)) begin
          case (sel_off)
            2'd0:    apb.prdata[CNT_W-1:0] = tdr[c];
            2'd1:    apb.prdata[7:0] = {load[c], ie[c], updw[c], en[c], arld[c], 1'b0, cks[c]};
            2'd2:    apb.prdata[1:0] = {udf[c], ovf[c]};
            default: apb.prdata[CNT_W-1:0] = tcnt[c];
          endcase
        end
      end
    end
  end

  // Shared free-running prescaler
  always_ff @(posedge pclk) begin
    if (preset) psc <= '0;
    else        psc <= psc + 4'd1;
  end

`ifdef TIMER_AUTO_RELOAD_EN
  // Auto-reload enable bit, only present when the feature is built in
  always_ff @(posedge pclk) begin
    if (preset) begin
      arld <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_ch[c] && sel_off == 2'd1) arld[c] <= apb.pwdata[3];
      end
    end
  end
`else
  assign arld = '0;
`endif

  // Channel registers: software writes, load/count/wrap, sticky flags with set winning over clear
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int c = 0; c < NCH; c++) begin
        tdr[c]  <= '0;
        tcnt[c] <= '0;
        cks[c]  <= '0;
      end
      load <= '0;
      ie   <= '0;
      updw <= '0;
      en   <= '0;
      udf  <= '0;
      ovf  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_ch[c] && sel_off == 2'd0) tdr[c] <= apb.pwdata[CNT_W-1:0];
        if (wr_ch[c] && sel_off == 2'd1) begin
          load[c] <= apb.pwdata[7];
          ie[c]   <= apb.pwdata[6];
          updw[c] <= apb.pwdata[5];
          en[c]   <= apb.pwdata[4];
          cks[c]  <= apb.pwdata[1:0];
        end
        if (load[c])              tcnt[c] <= tdr[c];
        else if (set_ovf[c])      tcnt[c] <= arld[c] ? tdr[c] : '0;
        else if (set_udf[c])      tcnt[c] <= arld[c] ? tdr[c] : '1;
        else if (en[c] && tick[c]) tcnt[c] <= updw[c] ? tcnt[c] - CNT_W'(1) : tcnt[c] + CNT_W'(1);
        ovf[c] <= set_ovf[c] | (ovf[c] & ~(wr_ch[c] && sel_off == 2'd2 && !apb.pwdata[0]));
        udf[c] <= set_udf[c] | (udf[c] & ~(wr_ch[c] && sel_off == 2'd2 && !apb.pwdata[1]));
      end
    end
  end

endmodule

// File: tb/tb_timer_multi_ch.sv
// Testbench for timer_multi_ch (NCH = 2, CNT_W = 16). A behavioural register model
// predicts irq, prdata and pslverr every cycle; directed sequences add literal checks.
module tb_timer_multi_ch;
  localparam int NCH   = 2;
  localparam int CNT_W = 16;
  localparam int MAXV  = (1 << CNT_W) - 1;
`ifdef TIMER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam int TCR_MASK = AR ? 'hFB : 'hF3;

  logic           pclk;
  logic           preset;
  logic [NCH-1:0] irq;
  int             checks = 0;
  int             errors = 0;

  timer_multi_ch_if bus ();

  timer_multi_ch #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .pclk   (pclk),
    .preset (preset),
    .apb    (bus),
    .irq    (irq)
  );

  initial pclk = 1'b0;
  // 10-unit clock, posedges at 5, 15, ...
  always #5 pclk = ~pclk;

  // Register model: plain integers per channel
  int m_tdr [NCH];
  int m_tcr [NCH];
  int m_tsr [NCH];
  int m_cnt [NCH];
  int m_psc;
  bit m_valid = 1'b0;

  function automatic bit modelErr(input int addr, input bit isWrite);
    int ch  = addr / 16;
    int off = addr % 16;
    return (ch >= NCH) || (off % 4 != 0) || (isWrite && off == 12);
  endfunction

  function automatic int modelRead(input int addr);
    int ch  = addr / 16;
    int off = addr % 16;
    if (ch >= NCH || off % 4 != 0) return 0;
    case (off)
      0:       return m_tdr[ch];
      4:       return m_tcr[ch];
      8:       return m_tsr[ch];
      default: return m_cnt[ch];
    endcase
  endfunction

  function automatic int modelIrq();
    int v = 0;
    for (int c = 0; c < NCH; c++)
      if ((m_tcr[c] & 'h40) != 0 && m_tsr[c] != 0) v = v | (1 << c);
    return v;
  endfunction

  // Advance the model one pclk edge from the bus values present at that edge
  always @(posedge pclk) begin
    automatic int  addr = int'(bus.paddr);
    automatic bit  wrOk = bus.psel && bus.penable && bus.pwrite && !modelErr(addr, 1'b1);
    if (preset) begin
      for (int c = 0; c < NCH; c++) begin
        m_tdr[c] <= 0;
        m_tcr[c] <= 0;
        m_tsr[c] <= 0;
        m_cnt[c] <= 0;
      end
      m_psc   <= 0;
      m_valid <= 1'b1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        automatic int cnt    = m_cnt[c];
        automatic int tcr    = m_tcr[c];
        automatic int tsr    = m_tsr[c];
        automatic int period = 2 << (tcr % 4);
        automatic bit tk     = (m_psc % period) == (period - 1);
        automatic bit reld   = AR && ((tcr & 'h08) != 0);
        automatic int flags  = 0;
        if ((tcr & 'h80) != 0) begin
          cnt = m_tdr[c];
        end else if ((tcr & 'h10) != 0 && tk) begin
          if ((tcr & 'h20) != 0) begin
            if (cnt == 0) begin flags = 2; cnt = reld ? m_tdr[c] : MAXV; end
            else cnt = cnt - 1;
          end else begin
            if (cnt == MAXV) begin flags = 1; cnt = reld ? m_tdr[c] : 0; end
            else cnt = cnt + 1;
          end
        end
        if (wrOk && addr / 16 == c) begin
          case (addr % 16)
            0:       m_tdr[c] <= int'(bus.pwdata) & MAXV;
            4:       m_tcr[c] <= int'(bus.pwdata) & TCR_MASK;
            8:       tsr = tsr & int'(bus.pwdata) & 3;
            default: ;
          endcase
        end
        m_tsr[c] <= tsr | flags;
        m_cnt[c] <= cnt;
      end
      m_psc <= (m_psc + 1) % 16;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model every cycle, 2 units after the negedge
  always @(negedge pclk) begin
    #2;
    if (m_valid) begin
      checkOutput("irq", 32'(irq), modelIrq());
      checkOutput("pready", 32'(bus.pready), 1);
      if (bus.psel && bus.penable) begin
        checkOutput("pslverr", 32'(bus.pslverr), 32'(modelErr(int'(bus.paddr), bus.pwrite)));
        if (!bus.pwrite) checkOutput("prdata", bus.prdata, modelRead(int'(bus.paddr)));
      end else if (!bus.psel) begin
        checkOutput("prdata_idle", bus.prdata, 0);
        checkOutput("pslverr_idle", 32'(bus.pslverr), 0);
      end
    end
  end

  // One APB transfer; called and returns at a negedge, two cycles long
  task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                               output logic [31:0] rdata, output logic err);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = data;
    @(negedge pclk);
    bus.penable = 1'b1;
    #2;
    rdata = bus.prdata;
    err   = bus.pslverr;
    @(negedge pclk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic doWrite(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        e;
    applyStimulus(1'b1, addr, data, d, e);
  endtask

  task automatic doRead(input logic [7:0] addr, output logic [31:0] d);
    logic e;
    applyStimulus(1'b0, addr, 32'h0, d, e);
  endtask

  // Abort if the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    logic [31:0] d;
    logic        e;
    bit          found;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0;  bus.pwdata = '0;
    preset = 1'b1;
    repeat (2) @(negedge pclk);
    preset = 1'b0;

    // Reset state of every register
    for (int a = 0; a < 32; a += 4) begin
      doRead(8'(a), d);
      checkOutput("reset_reg", d, 0);
    end
    checkOutput("reset_irq", 32'(irq), 0);

    // False underflow: freshly loaded down counter has no flag
    doWrite(8'h00, 32'h00FF);
    doWrite(8'h04, 32'h80);
    doWrite(8'h04, 32'h30);
    doRead(8'h08, d);
    checkOutput("false_udf_tsr", d, 0);
    doRead(8'h0C, d);
    checkOutput("false_udf_tcnt_le_ff", 32'(d <= 32'hFF), 1);

    // Real underflow from 2 at pclk/2
    doWrite(8'h00, 32'h0002);
    doWrite(8'h04, 32'h80);
    doWrite(8'h04, 32'h30);
    repeat (10) @(negedge pclk);
    doRead(8'h08, d);
    checkOutput("real_udf_tsr", d, 32'h02);
    doWrite(8'h04, 32'h00);
    doWrite(8'h08, 32'h00);
    doRead(8'h08, d);
    checkOutput("tsr_clear", d, 0);

    // Clear colliding with a new underflow: the set must win
    doWrite(8'h00, 32'h0000);
    doWrite(8'h04, 32'h80);
    doWrite(8'h08, 32'h00);
    for (int i = 0; i < 32 && m_psc != 15; i++) @(negedge pclk);
    doWrite(8'h04, 32'h33);
    for (int i = 0; i < 32 && m_psc != 14; i++) @(negedge pclk);
    doWrite(8'h08, 32'h00);
    doRead(8'h08, d);
    checkOutput("collision_tsr", d, 32'h02);
    doRead(8'h0C, d);
    checkOutput("collision_tcnt", d, 32'hFFFF);
    doWrite(8'h08, 32'h00);
    doRead(8'h08, d);
    checkOutput("collision_clear", d, 0);
    doWrite(8'h04, 32'h00);

    // Auto-reload / plain wrap on overflow
    doWrite(8'h00, 32'hFFFE);
    doWrite(8'h04, 32'h80);
    doWrite(8'h08, 32'h00);
    doWrite(8'h04, 32'h18);
    doRead(8'h04, d);
    checkOutput("tcr_arld_read", d, AR ? 32'h18 : 32'h10);
    repeat (12) @(negedge pclk);
    doWrite(8'h04, 32'h80);
    doWrite(8'h08, 32'h00);
    doWrite(8'h04, 32'h1B);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      doRead(8'h08, d);
      if (d[0]) found = 1'b1;
    end
    checkOutput("ovf_wait", 32'(found), 1);
    doRead(8'h08, d);
    checkOutput("ovf_tsr", d, 32'h01);
    doRead(8'h0C, d);
    checkOutput("wrap_tcnt", d, AR ? 32'hFFFE : 32'h0000);
    doRead(8'h04, d);
    checkOutput("tcr_read_slow", d, AR ? 32'h1B : 32'h13);
    doWrite(8'h04, 32'h00);
    doWrite(8'h08, 32'h00);

    // Interrupt masking and channel independence
    doWrite(8'h00, 32'hFFFF);
    doWrite(8'h10, 32'hFFFF);
    doWrite(8'h04, 32'h80);
    doWrite(8'h14, 32'h80);
    doWrite(8'h08, 32'h00);
    doWrite(8'h18, 32'h00);
    doWrite(8'h04, 32'h10);
    doWrite(8'h14, 32'h50);
    repeat (6) @(negedge pclk);
    checkOutput("irq_ch1_only", 32'(irq), 32'h2);
    doRead(8'h08, d);
    checkOutput("ch0_tsr_ovf", d, 32'h01);
    doWrite(8'h04, 32'h80);
    doWrite(8'h04, 32'h00);
    doWrite(8'h18, 32'h00);
    checkOutput("irq_cleared", 32'(irq), 0);
    doWrite(8'h14, 32'h00);
    doWrite(8'h10, 32'hABCD1234);
    doRead(8'h0C, d);
    checkOutput("ch0_tcnt_isolated", d, 32'hFFFF);
    doRead(8'h10, d);
    checkOutput("tdr_high_bits", d, 32'h1234);
    doWrite(8'h14, 32'hFFFFFFFF);
    doRead(8'h14, d);
    checkOutput("tcr_reserved", d, AR ? 32'hFB : 32'hF3);
    doWrite(8'h14, 32'h00);

    // Error responses leave state untouched
    applyStimulus(1'b0, 8'h20, 32'h0, d, e);
    checkOutput("err_read_unmapped", 32'(e), 1);
    checkOutput("err_read_data", d, 0);
    applyStimulus(1'b1, 8'h20, 32'h5, d, e);
    checkOutput("err_write_unmapped", 32'(e), 1);
    applyStimulus(1'b1, 8'h0C, 32'h1234, d, e);
    checkOutput("err_write_tcnt", 32'(e), 1);
    doRead(8'h0C, d);
    checkOutput("tcnt_after_err", d, 32'hFFFF);

    // Prescaler: cks = 3 gives 4 decrements over 64 counting edges
    doWrite(8'h00, 32'h0100);
    doWrite(8'h04, 32'h80);
    doWrite(8'h04, 32'h33);
    repeat (62) @(negedge pclk);
    doWrite(8'h04, 32'h03);
    doRead(8'h0C, d);
    checkOutput("prescaler_div16", d, 32'h00FC);

    repeat (2) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
